// File: rtl/bit_serial_adder_if.sv
// Start/done handshake bundle for the bit-serial adder: operands in, status and result out.
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/bit_serial_adder.sv
// WIDTH-bit adder built from one full-adder cell reused once per clock, LSB first,
// with the carry held in a flip-flop between bits.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  bit_serial_adder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_s_sr;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_fa_s;
  logic             w_fa_c;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_s_next;

  assign w_fa_s   = r_a_sr[0] ^ r_b_sr[0] ^ r_c;
  assign w_fa_c   = (r_a_sr[0] & r_b_sr[0]) | (r_a_sr[0] & r_c) | (r_b_sr[0] & r_c);
  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_s_next = {w_fa_s, r_s_sr[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_s_sr  <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_a_sr  <= bus.a;
            r_b_sr  <= bus.b;
            r_c     <= bus.cin;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_s_sr <= w_s_next;
          r_c    <= w_fa_c;
          if (w_last) begin
            // r_c still holds the carry into the MSB here, so ovf compares it with the carry out
            r_sum   <= w_s_next;
            r_cout  <= w_fa_c;
            r_ovf   <= r_c ^ w_fa_c;
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (r_state == S_RUN);
  assign bus.done = (r_state == S_DONE);
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;

endmodule
